// File: rtl/light_routine_scanner.sv
// LED bar scanner (bounce / rotate) with a cascaded BCD tick counter
// shown on active-low seven-segment digits.
module light_routine_scanner #(
  parameter int LED_COUNT  = 18,
  parameter int BAR_WIDTH  = 4,
  parameter int HEX_DIGITS = 4,
  parameter int PRESCALE   = 1
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic                              Enable,
  input  logic                              Mode,
  output logic [LED_COUNT+7*HEX_DIGITS-1:0] OutputBus
);

  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int POS_W = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [POS_W-1:0] POS_TOP  = POS_W'(LED_COUNT - BAR_WIDTH);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_COUNT - 1);

  localparam logic [0:0] DIR_UP   = 1'b0;
  localparam logic [0:0] DIR_DOWN = 1'b1;

  logic [PS_W-1:0]            prescale;
  logic [POS_W-1:0]           pos, pos_next;
  logic [0:0]                 dir, dir_next;
  logic [HEX_DIGITS-1:0][3:0] bcd, bcd_next;

  logic tick;
  logic clamp;

  assign tick  = Enable && (prescale == PS_LAST);
  // Leaving rotate mode with the bar past the bounce range snaps it back at once.
  assign clamp = !Mode && (pos > POS_TOP);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pos_next = pos;
    dir_next = dir;
    if (Mode) begin
      pos_next = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
    end else if (dir == DIR_UP) begin
      if (pos < POS_TOP) begin
        pos_next = pos + POS_W'(1);
      end else begin
        dir_next = DIR_DOWN;
        pos_next = pos - POS_W'(1);
      end
    end else begin
      if (pos != '0) begin
        pos_next = pos - POS_W'(1);
      end else begin
        dir_next = DIR_UP;
        pos_next = pos + POS_W'(1);
      end
    end
  end

  // Ripple carry across the digits within one cycle.
  always_comb begin
    logic carry;
    bcd_next = bcd;
    carry    = 1'b1;
    for (int k = 0; k < HEX_DIGITS; k++) begin
      if (carry) begin
        if (bcd[k] == 4'd9) begin
          bcd_next[k] = 4'd0;
        end else begin
          bcd_next[k] = bcd[k] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      prescale <= '0;
      pos      <= '0;
      dir      <= DIR_UP;
      // NOTE: the digit array is state the display depends on, so it is reset like any register.
      bcd      <= '0;
    end else begin
      if (Enable) begin
        prescale <= (prescale == PS_LAST) ? '0 : prescale + PS_W'(1);
      end
      if (clamp) begin
        pos <= POS_TOP;
        dir <= DIR_DOWN;
      end else if (tick) begin
        pos <= pos_next;
        dir <= dir_next;
      end
      if (tick) begin
        bcd <= bcd_next;
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [LED_COUNT-1:0]       leds;
  logic [HEX_DIGITS-1:0][6:0] segs;

  // Bit i is lit when its distance above pos, modulo the ring, is inside the bar.
  always_comb begin
    leds = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      int ofs;
      ofs = i - int'(pos);
      if (ofs < 0) ofs = ofs + LED_COUNT;
      leds[i] = (ofs < BAR_WIDTH);
    end
  end

  always_comb begin
    for (int k = 0; k < HEX_DIGITS; k++) begin
      segs[k] = seg7(bcd[k]);
    end
  end

  assign OutputBus = {leds, segs};

endmodule

// File: tb/tb_light_routine_scanner.sv
// Randomized bench for light_routine_scanner: two configurations checked every
// cycle against an arithmetic model, plus hand-computed scenario checks.
module tb_light_routine_scanner;

  localparam int N  = 18;
  localparam int B  = 4;
  localparam int HA = 4;
  localparam int PA = 1;
  localparam int HB = 2;
  localparam int PB = 3;
  localparam int WA = N + 7 * HA;
  localparam int WB = N + 7 * HB;

  localparam int PRES [2] = '{PA, PB};
  localparam int DIGS [2] = '{HA, HB};
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic Clock  = 1'b0;
  logic Reset  = 1'b1;
  logic Enable = 1'b0;
  logic Mode   = 1'b0;
  logic [WA-1:0] bus_a;
  logic [WB-1:0] bus_b;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  light_routine_scanner #(.LED_COUNT(N), .BAR_WIDTH(B), .HEX_DIGITS(HA), .PRESCALE(PA)) dut_a (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Mode(Mode), .OutputBus(bus_a)
  );

  light_routine_scanner #(.LED_COUNT(N), .BAR_WIDTH(B), .HEX_DIGITS(HB), .PRESCALE(PB)) dut_b (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Mode(Mode), .OutputBus(bus_b)
  );

  always #5 Clock = ~Clock;

  // Behavioural model: bar position as an integer, counter as a plain tick count.
  int m_ps  [2] = '{0, 0};
  int m_pos [2] = '{0, 0};
  int m_cnt [2] = '{0, 0};
  bit m_up  [2] = '{1'b1, 1'b1};

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  always @(posedge Clock or negedge Reset) begin
    bit tick;
    for (int j = 0; j < 2; j++) begin
      if (!Reset) begin
        m_ps[j] = 0; m_pos[j] = 0; m_up[j] = 1'b1; m_cnt[j] = 0;
      end else begin
        tick = Enable && (m_ps[j] == PRES[j] - 1);
        if (Enable) m_ps[j] = (m_ps[j] + 1) % PRES[j];
        if (!Mode && m_pos[j] > N - B) begin
          m_pos[j] = N - B;
          m_up[j]  = 1'b0;
        end else if (tick) begin
          if (Mode) m_pos[j] = (m_pos[j] + 1) % N;
          else if (m_up[j]) begin
            if (m_pos[j] < N - B) m_pos[j] = m_pos[j] + 1;
            else begin m_up[j] = 1'b0; m_pos[j] = m_pos[j] - 1; end
          end else begin
            if (m_pos[j] > 0) m_pos[j] = m_pos[j] - 1;
            else begin m_up[j] = 1'b1; m_pos[j] = m_pos[j] + 1; end
          end
        end
        if (tick) m_cnt[j] = (m_cnt[j] + 1) % pow10(DIGS[j]);
      end
    end
  end

  function automatic logic [63:0] expected(input int j);
    logic [63:0] v;
    int h;
    v = '0;
    h = DIGS[j];
    for (int i = 0; i < N; i++)
      if (((i - m_pos[j] + N) % N) < B) v[7*h+i] = 1'b1;
    for (int k = 0; k < h; k++) begin
      int d;
      d = (m_cnt[j] / pow10(k)) % 10;
      v[7*k +: 7] = SEG_TAB[d];
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (cmp_on) begin
      check("model_a", 64'(bus_a), expected(0));
      check("model_b", 64'(bus_b), expected(1));
    end
  end

  function automatic logic [63:0] leds_a();
    return 64'(bus_a[WA-1 -: N]);
  endfunction

  function automatic logic [63:0] leds_b();
    return 64'(bus_b[WB-1 -: N]);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #2;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    @(posedge Clock);
    #2;
    Reset = 1'b1;
  endtask

  initial begin
    #1 Reset = 1'b0;
    Enable = 1'b1;
    #2;
    check("reset_a", 64'(bus_a), 64'({18'h0000F, {4{7'h40}}}));
    check("reset_b", 64'(bus_b), 64'({18'h0000F, {2{7'h40}}}));
    cmp_on = 1'b1;
    @(posedge Clock);
    #2 Reset = 1'b1;

    // Bounce from reset
    Mode = 1'b0; do_reset();
    step(14); check("bounce_14", leds_a(), 64'h3C000);
    step(14); check("bounce_28", leds_a(), 64'h0000F);
    check("bcd_28", 64'(bus_a[27:0]), 64'({7'h40, 7'h40, 7'h24, 7'h00}));
    step(1);  check("bounce_29", leds_a(), 64'h0001E);

    // Rotate wraps across the top bit
    Mode = 1'b1; do_reset();
    step(17); check("rotate_17", leds_a(), 64'h20007);
    step(1);  check("rotate_18", leds_a(), 64'h0000F);

    // Rotate to bounce clamp
    Mode = 1'b1; do_reset();
    step(16); check("rotate_16", leds_a(), 64'h30003);
    Mode = 1'b0;
    step(1);  check("clamp", leds_a(), 64'h3C000);
    step(1);  check("clamp_next", leds_a(), 64'h1E000);

    // Counter wrap on the two-digit, prescale-3 instance
    Mode = 1'b0; do_reset();
    step(297); check("bcd_99", 64'(bus_b[13:0]), 64'({7'b0010000, 7'b0010000}));
    step(3);   check("bcd_wrap", 64'(bus_b[13:0]), 64'({7'h40, 7'h40}));

    // Enable gating with prescale 3
    Mode = 1'b0; do_reset();
    step(4);  check("pre_leds", leds_b(), 64'h0001E);
    check("pre_bcd", 64'(bus_b[13:0]), 64'({7'h40, 7'h79}));
    Enable = 1'b0;
    step(5);  check("frozen_leds", leds_b(), 64'h0001E);
    check("frozen_bcd", 64'(bus_b[13:0]), 64'({7'h40, 7'h79}));
    Enable = 1'b1;
    step(1);  check("no_tick_yet", leds_b(), 64'h0001E);
    step(1);  check("tick_leds", leds_b(), 64'h0003C);
    check("tick_bcd", 64'(bus_b[13:0]), 64'({7'h40, 7'h24}));

    // Asynchronous reset between edges
    Mode = 1'b0; do_reset();
    step(7);
    #1 Reset = 1'b0;
    #1;
    check("async_rst_a", 64'(bus_a), 64'({18'h0000F, {4{7'h40}}}));
    check("async_rst_b", 64'(bus_b), 64'({18'h0000F, {2{7'h40}}}));
    @(posedge Clock);
    #2 Reset = 1'b1;

    // Randomized traffic, compared every cycle against the model
    for (int c = 0; c < 3000; c++) begin
      step(1);
      Enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) Mode = ~Mode;
      if ($urandom_range(0, 499) == 0) begin
        Reset = 1'b0;
        #2;
        Reset = 1'b1;
      end
    end

    step(2);
    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
